fft_radix2_sequencer: RTL

Controller that runs a complete in-place radix-2 DIT FFT of N = 2^LOG2N points through one pipelined butterfly unit. It walks all LOG2N stages and emits per-butterfly sample-memory read addresses, twiddle-ROM addresses and the butterfly enable. A write-back address delay line is matched to the butterfly latency, and stages are separated so that read-after-write hazards cannot occur. It sits between the FFT accelerator's command interface and the sample RAM, twiddle ROM and butterfly datapath. Input data in RAM is already in bit-reversed order.

---
 rtl/fft_seq_pkg.sv | 22 ++
 rtl/fft_seq_addr_gen.sv | 34 +++
 rtl/fft_radix2_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_seq_pkg.sv
// Shared state encoding, constants and write-back entry layout for the radix-2 FFT sequencer.
package fft_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int DEFAULT_LATENCY = 11;
    localparam int MAX_LOG2N       = 12;
    localparam int STAGE_W         = 4;

    // Addresses are stored at the widest legal size and sliced down by the sequencer.
    typedef struct packed {
        logic                 tag;
        logic [MAX_LOG2N-1:0] addr_a;
        logic [MAX_LOG2N-1:0] addr_b;
    } wb_entry_t;

endpackage

// File: rtl/fft_seq_addr_gen.sv
// Combinational (stage, butterfly index) to operand/twiddle address mapping for in-place radix-2 DIT.
module fft_seq_addr_gen
    import fft_seq_pkg::*;
#(
    parameter int LOG2N = 8
)
(
    input  logic [STAGE_W-1:0] stage,
    input  logic [LOG2N-2:0]   k,
    output logic [LOG2N-1:0]   addr_a,
    output logic [LOG2N-1:0]   addr_b,
    output logic [LOG2N-2:0]   tw_addr
);

    localparam int KW = LOG2N - 1;
    localparam logic [KW-1:0]      K_ONE  = KW'(1);
    localparam logic [LOG2N-1:0]   A_ONE  = LOG2N'(1);
    localparam logic [STAGE_W-1:0] TW_TOP = STAGE_W'(LOG2N - 1);

    logic [KW-1:0] j_mask_s;
    logic [KW-1:0] j_s;
    logic [KW-1:0] g_bits_s;

    // In the last stage the mask wraps to all-ones, so every k is its own offset j.
    always_comb begin
        j_mask_s = (K_ONE << stage) - K_ONE;
        j_s      = k & j_mask_s;
        g_bits_s = k & ~j_mask_s;
        addr_a   = {g_bits_s, 1'b0} | {1'b0, j_s};
        addr_b   = addr_a | (A_ONE << stage);
        tw_addr  = j_s << (TW_TOP - stage);
    end

endmodule

// File: rtl/fft_radix2_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT with latency-matched write-back.
// Optional bfly_valid cross-check is built when FFT_SEQ_VALID_CHECK_EN is defined.
module fft_radix2_sequencer
    import fft_seq_pkg::*;
#(
    parameter int LOG2N   = 8,
    parameter int LATENCY = DEFAULT_LATENCY
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             bfly_enable,
    input  logic             bfly_valid,
    output logic             wb_en,
    output logic [LOG2N-1:0] wb_addr_a,
    output logic [LOG2N-1:0] wb_addr_b,
    output logic             err
);

    localparam int KW = LOG2N - 1;
    localparam int DW = $clog2(LATENCY + 1);
    localparam logic [KW-1:0]      K_LAST = {KW{1'b1}};
    localparam logic [KW-1:0]      K_ONE  = KW'(1);
    localparam logic [DW-1:0]      D_LAST = DW'(LATENCY);
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2N - 1);
    localparam logic [STAGE_W-1:0] S_ONE  = STAGE_W'(1);

    seq_state_t         state_r;
    seq_state_t         state_nx_s;
    logic [STAGE_W-1:0] stage_r;
    logic [STAGE_W-1:0] stage_nx_s;
    logic [KW-1:0]      k_r;
    logic [KW-1:0]      k_nx_s;
    logic [DW-1:0]      drain_r;
    logic [DW-1:0]      drain_nx_s;
    logic [LOG2N-1:0]   gen_a_s;
    logic [LOG2N-1:0]   gen_b_s;
    logic [KW-1:0]      gen_tw_s;
    wb_entry_t          head_s;
    wb_entry_t          dline_r [LATENCY+1];

    // Next-state and counter lookahead; addresses are generated from the lookahead so they register with rd_en.
    always_comb begin
        state_nx_s = state_r;
        stage_nx_s = stage_r;
        k_nx_s     = k_r;
        drain_nx_s = drain_r;
        if (abort) begin
            state_nx_s = IDLE;
            stage_nx_s = '0;
            k_nx_s     = '0;
            drain_nx_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_nx_s = ISSUE;
                        stage_nx_s = '0;
                        k_nx_s     = '0;
                        drain_nx_s = '0;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                ISSUE: begin
                    if (k_r == K_LAST) begin
                        state_nx_s = DRAIN;
                        drain_nx_s = '0;
                    end else begin
                        k_nx_s = k_r + K_ONE;
                    end
                end
                DRAIN: begin
                    if (drain_r != D_LAST) begin
                        drain_nx_s = drain_r + DW'(1);
                    end else if (stage_r == S_LAST) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = ISSUE;
                        stage_nx_s = stage_r + S_ONE;
                        k_nx_s     = '0;
                        drain_nx_s = '0;
                    end
                end
                DONE:    state_nx_s = IDLE;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    fft_seq_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
        .stage   (stage_nx_s),
        .k       (k_nx_s),
        .addr_a  (gen_a_s),
        .addr_b  (gen_b_s),
        .tw_addr (gen_tw_s)
    );

    // Sequencer state, counters and all read-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            stage_r     <= '0;
            k_r         <= '0;
            drain_r     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr_a   <= '0;
            rd_addr_b   <= '0;
            tw_addr     <= '0;
            bfly_enable <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            stage_r     <= stage_nx_s;
            k_r         <= k_nx_s;
            drain_r     <= drain_nx_s;
            busy        <= (state_nx_s != IDLE);
            done        <= (state_nx_s == DONE);
            rd_en       <= (state_nx_s == ISSUE);
            rd_addr_a   <= (state_nx_s == ISSUE) ? gen_a_s  : '0;
            rd_addr_b   <= (state_nx_s == ISSUE) ? gen_b_s  : '0;
            tw_addr     <= (state_nx_s == ISSUE) ? gen_tw_s : '0;
            bfly_enable <= !abort && ((state_r == ISSUE) || (state_r == DRAIN));
        end
    end

    always_comb begin
        head_s                   = '0;
        head_s.tag               = rd_en;
        head_s.addr_a[LOG2N-1:0] = rd_addr_a;
        head_s.addr_b[LOG2N-1:0] = rd_addr_b;
    end

    // Write-back delay line; abort flushes every pending tag so no stale write can escape.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            for (int i = 0; i <= LATENCY; i++) begin
                dline_r[i] <= '0;
            end
        end else begin
            dline_r[0] <= head_s;
            for (int i = 1; i <= LATENCY; i++) begin
                dline_r[i] <= dline_r[i-1];
            end
        end
    end

    assign wb_en     = dline_r[LATENCY].tag;
    assign wb_addr_a = dline_r[LATENCY].addr_a[LOG2N-1:0];
    assign wb_addr_b = dline_r[LATENCY].addr_b[LOG2N-1:0];

`ifdef FFT_SEQ_VALID_CHECK_EN
    localparam logic [DW-1:0] D_ONE = DW'(1);

    logic [DW-1:0] en_cnt_r;
    logic          err_r;
    logic          chk_s;
    logic          start_acc_s;

    assign start_acc_s = (state_r == IDLE) && start && !abort;
    assign chk_s       = bfly_enable && (en_cnt_r == D_LAST);

    // Butterfly output is only meaningful once the pipe has advanced LATENCY times without a gap.
    always_ff @(posedge clk) begin
        if (!rst_n || abort || !bfly_enable) begin
            en_cnt_r <= '0;
        end else if (en_cnt_r != D_LAST) begin
            en_cnt_r <= en_cnt_r + D_ONE;
        end else begin
            en_cnt_r <= en_cnt_r;
        end
    end

    // Sticky valid/tag mismatch flag, cleared when a new transform is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n || start_acc_s) begin
            err_r <= 1'b0;
        end else if (chk_s && (bfly_valid != dline_r[LATENCY].tag)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    logic unused_valid_s;
    assign unused_valid_s = bfly_valid;
    assign err            = 1'b0;
`endif

endmodule
